// File: rtl/axi4l_mmio_periph.sv
// AXI4-Lite MMIO slave: console byte FIFO with a valid/ready output stream,
// a sticky test-pass flag, an unmapped-access error flag and a programmable
// periodic timer interrupt. Read and write channels are fully independent.
module axi4l_mmio_periph #(
    parameter int          CON_DEPTH  = 16,
    parameter int          TIMER_IRQ  = 3,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data,
    output logic [31:0] irq,
    output logic        tests_passed,
    output logic        err
);

    localparam int PTR_W = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CON_DEPTH);

    localparam logic [31:0] ADDR_CON     = 32'h1000_0000;
    localparam logic [31:0] ADDR_PASS    = 32'h2000_0000;
    localparam logic [31:0] ADDR_PERIOD  = 32'h3000_0000;
    localparam logic [31:0] ADDR_PENDING = 32'h3000_0004;

    // write channel state
    logic        aw_lat_q, aw_lat_d;
    logic        w_lat_q, w_lat_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;

    // read channel state
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    // console FIFO
    logic [7:0]       mem_q [CON_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;

    // flags and timer
    logic        tests_passed_q, tests_passed_d;
    logic        err_q, err_d;
    logic [31:0] period_q, period_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic wr_push_req, fifo_full, wr_exec, push, pop, tick;

    assign s_awready    = !aw_lat_q;
    assign s_wready     = !w_lat_q;
    assign s_bvalid     = bvalid_q;
    assign s_arready    = !rvalid_q;
    assign s_rvalid     = rvalid_q;
    assign s_rdata      = rdata_q;
    assign con_valid    = (fill_q != '0);
    assign con_data     = mem_q[rd_ptr_q];
    assign tests_passed = tests_passed_q;
    assign err          = err_q;

    // A console push stalls on a full FIFO; a pop in the same cycle does not
    // make room until the next cycle, which keeps the full check registered.
    assign wr_push_req = (awaddr_q == ADDR_CON) && wstrb_q[0];
    assign fifo_full   = (fill_q == FULL_CNT);
    assign wr_exec     = aw_lat_q && w_lat_q && !bvalid_q && !(wr_push_req && fifo_full);
    assign push        = wr_exec && wr_push_req;
    assign pop         = con_valid && con_ready;
    assign tick        = (period_q != '0) && (count_q <= 32'd1);

    // only the timer line is ever driven
    always_comb begin
        irq            = '0;
        irq[TIMER_IRQ] = pending_q;
    end

    // write channel: independent AW/W latches, response held until bready
    always_comb begin
        aw_lat_d = aw_lat_q;
        w_lat_d  = w_lat_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        if (s_awvalid && !aw_lat_q) begin
            aw_lat_d = 1'b1;
            awaddr_d = s_awaddr;
        end
        if (s_wvalid && !w_lat_q) begin
            w_lat_d = 1'b1;
            wdata_d = s_wdata;
            wstrb_d = s_wstrb;
        end
        if (wr_exec) bvalid_d = 1'b1;
        if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
            aw_lat_d = 1'b0;
            w_lat_d  = 1'b0;
        end
    end

    // console FIFO pointers and fill count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      fill_d = fill_q + CNT_W'(1);
        else if (pop && !push) fill_d = fill_q - CNT_W'(1);
    end

    // register side effects of writes, timer countdown and the read response
    always_comb begin
        tests_passed_d = tests_passed_q;
        err_d          = err_q;
        period_d       = period_q;
        count_d        = count_q;
        pending_d      = pending_q;
        rvalid_d       = rvalid_q;
        rdata_d        = rdata_q;

        if (period_q != '0) count_d = (count_q <= 32'd1) ? period_q : count_q - 32'd1;

        if (wr_exec) begin
            case (awaddr_q)
                ADDR_CON: ;
                ADDR_PASS:
                    if (wdata_q == PASS_MAGIC && wstrb_q == 4'hF) tests_passed_d = 1'b1;
                ADDR_PERIOD: begin
                    for (int i = 0; i < 4; i++)
                        if (wstrb_q[i]) period_d[8*i +: 8] = wdata_q[8*i +: 8];
                    count_d = period_d;
                end
                ADDR_PENDING:
                    if (wdata_q[0] && wstrb_q[0]) pending_d = 1'b0;
                default: err_d = 1'b1;
            endcase
        end
        // timer expiry overrides a coincident W1C
        if (tick) pending_d = 1'b1;

        if (s_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            case (s_araddr)
                ADDR_CON:     rdata_d = {{(32-CNT_W){1'b0}}, fill_q};
                ADDR_PASS:    rdata_d = {31'b0, tests_passed_q};
                ADDR_PERIOD:  rdata_d = period_q;
                ADDR_PENDING: rdata_d = {31'b0, pending_q};
                default: begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            endcase
        end
        if (rvalid_q && s_rready) rvalid_d = 1'b0;
    end

    // state registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_lat_q       <= 1'b0;
            w_lat_q        <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bvalid_q       <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            tests_passed_q <= 1'b0;
            err_q          <= 1'b0;
            period_q       <= '0;
            count_q        <= '0;
            pending_q      <= 1'b0;
        end else begin
            aw_lat_q       <= aw_lat_d;
            w_lat_q        <= w_lat_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            bvalid_q       <= bvalid_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            tests_passed_q <= tests_passed_d;
            err_q          <= err_d;
            period_q       <= period_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata_q[7:0];
    end

endmodule
